// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types: mul/div op encoding, sequencer states and op helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Operand a is treated as two's complement
  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Operand b is treated as two's complement (mulhsu keeps b unsigned)
  function automatic logic is_b_signed_op(input muldiv_op_t op);
    return is_signed_op(op) && (op != MD_MULHSU);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one hi/lo register pair.
module muldiv_core
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi_nxt_c,
  output logic [WIDTH-1:0] lo_nxt_c
);

  logic             is_div_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_diff;

  // One iteration: mul keeps {acc_hi, multiplier}; div keeps {remainder, dividend/quotient}
  always_comb begin
    hi_nxt_c = hi_q;
    lo_nxt_c = lo_q;
    add_sum  = '0;
    shifted  = '0;
    sub_diff = '0;
    if (is_div_q) begin
      shifted  = {hi_q, lo_q[WIDTH-1]};
      sub_diff = shifted - {1'b0, opnd_q};
      hi_nxt_c = sub_diff[WIDTH] ? shifted[WIDTH-1:0] : sub_diff[WIDTH-1:0];
      lo_nxt_c = {lo_q[WIDTH-2:0], ~sub_diff[WIDTH]};
    end else begin
      add_sum              = {1'b0, hi_q} + {1'b0, opnd_q & {WIDTH{lo_q[0]}}};
      {hi_nxt_c, lo_nxt_c} = {add_sum, lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else if (load) begin
      is_div_q <= is_div_op(op);
      hi_q     <= '0;
      lo_q     <= is_div_op(op) ? a_mag : b_mag;
      opnd_q   <= is_div_op(op) ? b_mag : a_mag;
    end else if (step) begin
      hi_q <= hi_nxt_c;
      lo_q <= lo_nxt_c;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle mul/div sequencer: accepts one op, stalls the pipe, returns a registered result.
module muldiv_sequencer
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  muldiv_op_t       req_op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             stall,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  muldiv_op_t         op_q;
  logic               sa_q, sb_q;
  logic               load, step, res_ld, accept;
  logic [WIDTH-1:0]   res_d;
  logic               a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, calc_res;

  // Request-side operand conditioning and one-cycle divide special cases
  always_comb begin
    a_neg    = is_signed_op(req_op) & rs1_data[WIDTH-1];
    b_neg    = is_b_signed_op(req_op) & rs2_data[WIDTH-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div_op(req_op) & (rs2_data == '0);
    div_ovf  = is_div_op(req_op) & is_signed_op(req_op) &
               (rs1_data == MIN_NEG) & (rs2_data == '1);
    if (div_zero) special_res = is_rem_op(req_op) ? rs1_data : '1;
    else          special_res = is_rem_op(req_op) ? '0 : rs1_data;
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .op       (req_op),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .hi_nxt_c (hi_nxt),
    .lo_nxt_c (lo_nxt)
  );

  // Sign fix-up on the final iteration's output so the result register is valid in DONE
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quo_fix  = (sa_q ^ sb_q) ? -lo_nxt : lo_nxt;
    rem_fix  = sa_q ? -hi_nxt : hi_nxt;
    case (op_q)
      MD_MUL:                       calc_res = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              calc_res = quo_fix;
      default:                      calc_res = rem_fix;
    endcase
  end

  assign accept = (state_q == IDLE) & req_valid & ~flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    resp_valid = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    res_ld     = 1'b0;
    res_d      = calc_res;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          load  = 1'b1;
          cnt_d = CNT_W'(WIDTH);
          if (div_zero | div_ovf) begin
            state_d = DONE;
            res_ld  = 1'b1;
            res_d   = special_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            res_ld  = 1'b1;
          end
        end
      end
      DONE: begin
        resp_valid = ~flush;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= MD_MUL;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      resp_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= req_op;
        sa_q <= a_neg;
        sb_q <= b_neg;
      end
      if (res_ld) resp_data <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table with scoreboard plus flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;
  import rv32i_types::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  muldiv_op_t   req_op;
  logic [W-1:0] rs1_data, rs2_data;
  logic         flush;
  logic         stall, resp_valid;
  logic [W-1:0] resp_data;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] sb_q[$];

  typedef struct {
    muldiv_op_t   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;
  vec_t vecs[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_resp_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_data", resp_data, e);
      end
    end
  end

  task automatic run_op(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat);
    int  cyc;
    int  stalls;
    bit  seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; rs1_data = a; rs2_data = b;
    sb_q.push_back(exp);
    cyc = 0; stalls = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (stall) stalls++;
      if (resp_valid) seen = 1;
      else cyc++;
    end
    check($sformatf("latency op%0d", op), seen ? W'(cyc) : '1, W'(lat));
    check($sformatf("stall_cycles op%0d", op), W'(stalls), W'(lat));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int t1, t2, np;
    rst_n = 1'b0; req_valid = 1'b0; req_op = MD_MUL; rs1_data = '0; rs2_data = '0; flush = 1'b0;

    vecs.push_back('{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{MD_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 33});
    vecs.push_back('{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{MD_DIVU,   32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{MD_REMU,   32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{MD_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{MD_DIV,    32'h8000_0000,  32'd2,         32'hC000_0000, 33});
    vecs.push_back('{MD_DIVU,   32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 33});
    vecs.push_back('{MD_REMU,   32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 33});
    vecs.push_back('{MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{MD_REM,    32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{MD_DIV,    32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{MD_REMU,   32'h8000_0000,  32'd0,         32'h8000_0000, 1});
    vecs.push_back('{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33});

    #2;
    check("reset stall", W'(stall), '0);
    check("reset resp_valid", W'(resp_valid), '0);
    check("reset resp_data", resp_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush a divide in cycle 10; no response may follow
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = MD_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush cycle10 stall", W'(stall), W'(1));
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush cycle11 stall", W'(stall), '0);
    repeat (40) @(negedge clk);
    run_op(MD_MUL, 32'd3, 32'd4, 32'd12, 33);

    // Asynchronous reset mid-CALC clears outputs immediately
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = MD_MUL; rs1_data = 32'd3; rs2_data = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    check("midcalc stall", W'(stall), W'(1));
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("midreset stall", W'(stall), '0);
    check("midreset resp_valid", W'(resp_valid), '0);
    check("midreset resp_data", resp_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back multiplies: pulses WIDTH+2 cycles apart
    t1 = -1; t2 = -1; np = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_valid = 1'b1; req_op = MD_MUL; rs1_data = 32'd5; rs2_data = 32'd6;
        sb_q.push_back(32'd30);
      end else if (c == 34) begin
        rs1_data = 32'd9; rs2_data = 32'd11;
        sb_q.push_back(32'd99);
      end else if (c == 68) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (resp_valid) begin
        np++;
        if (np == 1) t1 = c;
        else if (np == 2) t2 = c;
      end
    end
    check("b2b pulse count", W'(np), W'(2));
    check("b2b first resp cycle", W'(t1), W'(33));
    check("b2b second resp cycle", W'(t2), W'(67));

    repeat (3) @(negedge clk);
    check("scoreboard drained", W'(sb_q.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
